mem_bus_arbiter: RTL and testbench

//  Shares one single-beat memory port between instruction fetch (ibus) and the

---
 rtl/mem_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter (ibus fetch / dbus memory stage) in front of one single-beat memory port.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise dbus wins every tie.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 9
) (
   input  logic        clk,
   input  logic        reset_n,
   // ibus: read-only fetch port
   input  logic        i_valid,
   input  logic [63:0] i_addr,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   output logic [63:0] i_data,
   // dbus: load/store port
   input  logic        d_valid,
   input  logic [63:0] d_addr,
   input  logic [2:0]  d_size,
   input  logic [7:0]  d_strobe,
   input  logic [63:0] d_wdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic [63:0] d_data,
   // downstream memory port
   output logic        m_valid,
   output logic        m_write,
   output logic [63:0] m_addr,
   output logic [2:0]  m_size,
   output logic [7:0]  m_strobe,
   output logic [63:0] m_wdata,
   input  logic        m_ready,
   input  logic [63:0] m_rdata,
   output logic        timeout,
   // observation of internal state
   output logic [1:0]  dbg_state,
   output logic        dbg_last_grant
);

   // Handshake: a requester holds x_valid (and its fields) until x_data_ok.
   // x_addr_ok pulses in the IDLE cycle the request wins; m_valid rises the next
   // cycle and stays up with stable m_* until the cycle m_ready pulses, which is
   // also the cycle x_data_ok pulses. At least one IDLE cycle separates grants.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   localparam logic [2:0]       MSIZE4   = 3'd2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t            state_q,      state_d;
   grant_t            last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic              timeout_q,    timeout_d;
   logic              m_valid_q,    m_valid_d;
   logic              m_write_q,    m_write_d;
   logic [63:0]       m_addr_q,     m_addr_d;
   logic [2:0]        m_size_q,     m_size_d;
   logic [7:0]        m_strobe_q,   m_strobe_d;
   logic [63:0]       m_wdata_q,    m_wdata_d;

   logic              pick_d;
   logic              done_ok;
   logic              done_abort;

`ifdef MEM_ARB_RR_EN
   // On a tie the side that was not served last wins.
   assign pick_d = d_valid & (~i_valid | (last_grant_q == GRANT_I));
`else
   assign pick_d = d_valid;
`endif

   assign done_ok    = (state_q != S_IDLE) & m_ready;
   assign done_abort = (state_q != S_IDLE) & ~m_ready & (cnt_q >= CNT_LAST);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      timeout_d    = timeout_q;
      m_valid_d    = m_valid_q;
      m_write_d    = m_write_q;
      m_addr_d     = m_addr_q;
      m_size_d     = m_size_q;
      m_strobe_d   = m_strobe_q;
      m_wdata_d    = m_wdata_q;
      i_addr_ok    = 1'b0;
      i_data_ok    = 1'b0;
      i_data       = '0;
      d_addr_ok    = 1'b0;
      d_data_ok    = 1'b0;
      d_data       = '0;

      case (state_q)
         S_IDLE: begin
            if (pick_d) begin
               d_addr_ok  = 1'b1;
               m_valid_d  = 1'b1;
               m_write_d  = |d_strobe;
               m_addr_d   = d_addr;
               m_size_d   = d_size;
               m_strobe_d = d_strobe;
               m_wdata_d  = d_wdata;
               cnt_d      = '0;
               state_d    = S_BUSY_D;
            end else if (i_valid) begin
               i_addr_ok  = 1'b1;
               m_valid_d  = 1'b1;
               m_write_d  = 1'b0;
               m_addr_d   = i_addr;
               m_size_d   = MSIZE4;
               m_strobe_d = '0;
               m_wdata_d  = '0;
               cnt_d      = '0;
               state_d    = S_BUSY_I;
            end
         end

         S_BUSY_I, S_BUSY_D: begin
            if (done_ok || done_abort) begin
               // A timed-out access still answers, with zero data, so the pipeline drains.
               if (state_q == S_BUSY_I) begin
                  i_data_ok    = 1'b1;
                  i_data       = done_ok ? m_rdata : '0;
                  last_grant_d = GRANT_I;
               end else begin
                  d_data_ok    = 1'b1;
                  d_data       = done_ok ? m_rdata : '0;
                  last_grant_d = GRANT_D;
               end
               m_valid_d = 1'b0;
               state_d   = S_IDLE;
               if (done_abort) begin
                  timeout_d = 1'b1;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            m_valid_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase

      // Combinational handshakes stay quiet while reset is held.
      if (!reset_n) begin
         i_addr_ok = 1'b0;
         i_data_ok = 1'b0;
         i_data    = '0;
         d_addr_ok = 1'b0;
         d_data_ok = 1'b0;
         d_data    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= GRANT_I;
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
         m_valid_q    <= 1'b0;
         m_write_q    <= 1'b0;
         m_addr_q     <= '0;
         m_size_q     <= '0;
         m_strobe_q   <= '0;
         m_wdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
         m_valid_q    <= m_valid_d;
         m_write_q    <= m_write_d;
         m_addr_q     <= m_addr_d;
         m_size_q     <= m_size_d;
         m_strobe_q   <= m_strobe_d;
         m_wdata_q    <= m_wdata_d;
      end
   end

   assign m_valid        = m_valid_q;
   assign m_write        = m_write_q;
   assign m_addr         = m_addr_q;
   assign m_size         = m_size_q;
   assign m_strobe       = m_strobe_q;
   assign m_wdata        = m_wdata_q;
   assign timeout        = timeout_q;
   assign dbg_state      = state_q;
   assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (small timeout so the abort path is reachable).
// Tie expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_bus_arbiter;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BI   = 2'd1;
   localparam logic [1:0] ST_BD   = 2'd2;
   localparam logic [2:0] MSIZE4  = 3'd2;

   logic        clk;
   logic        reset_n;
   logic        i_valid;
   logic [63:0] i_addr;
   logic        i_addr_ok, i_data_ok;
   logic [63:0] i_data;
   logic        d_valid;
   logic [63:0] d_addr;
   logic [2:0]  d_size;
   logic [7:0]  d_strobe;
   logic [63:0] d_wdata;
   logic        d_addr_ok, d_data_ok;
   logic [63:0] d_data;
   logic        m_valid, m_write;
   logic [63:0] m_addr;
   logic [2:0]  m_size;
   logic [7:0]  m_strobe;
   logic [63:0] m_wdata;
   logic        m_ready;
   logic [63:0] m_rdata;
   logic        timeout;
   logic [1:0]  dbg_state;
   logic        dbg_last_grant;

   int vec_cnt = 0;
   int err_cnt = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
      .i_data_ok(i_data_ok), .i_data(i_data),
      .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
      .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_data(d_data),
      .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_size(m_size),
      .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
      .timeout(timeout), .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1ns after the rising edge; checks happen 2ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      i_valid = 1'b0; i_addr = '0;
      d_valid = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
      m_ready = 1'b0; m_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      i_valid = 1'b1;
      d_valid = 1'b1;
      #3;
      vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
      vec_cnt++; if (timeout !== 1'b0) begin err_cnt++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
      vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
      vec_cnt++; if (dbg_last_grant !== 1'b0) begin err_cnt++; $display("FAIL rst_last_grant: got %0b want 0", dbg_last_grant); end
      vec_cnt++; if ({i_addr_ok, d_addr_ok} !== 2'b00) begin err_cnt++; $display("FAIL rst_addr_ok: got %b want 00", {i_addr_ok, d_addr_ok}); end
      vec_cnt++; if ({m_addr, m_wdata} !== 128'd0) begin err_cnt++; $display("FAIL rst_m_fields: got %h want 0", {m_addr, m_wdata}); end
      step();
      clear_inputs();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_ibus_read();
      // cycle 0
      i_valid = 1'b1; i_addr = 64'h8000_0000;
      settle();
      vec_cnt++; if (i_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL ird_addr_ok: got %0b want 1", i_addr_ok); end
      vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL ird_mvalid_c0: got %0b want 0", m_valid); end
      // cycle 1
      step(); settle();
      vec_cnt++; if (m_valid !== 1'b1) begin err_cnt++; $display("FAIL ird_mvalid_c1: got %0b want 1", m_valid); end
      vec_cnt++; if (m_addr !== 64'h8000_0000) begin err_cnt++; $display("FAIL ird_maddr: got %h want 80000000", m_addr); end
      vec_cnt++; if ({m_write, m_size, m_strobe} !== {1'b0, MSIZE4, 8'h00}) begin err_cnt++; $display("FAIL ird_mfields: got %b want 0_010_00000000", {m_write, m_size, m_strobe}); end
      vec_cnt++; if (dbg_state !== ST_BI) begin err_cnt++; $display("FAIL ird_state_c1: got %0d want 1", dbg_state); end
      vec_cnt++; if ({i_addr_ok, i_data_ok} !== 2'b00) begin err_cnt++; $display("FAIL ird_quiet_c1: got %b want 00", {i_addr_ok, i_data_ok}); end
      // cycle 2
      step(); settle();
      vec_cnt++; if (m_valid !== 1'b1) begin err_cnt++; $display("FAIL ird_mvalid_c2: got %0b want 1", m_valid); end
      // cycle 3
      step();
      m_ready = 1'b1; m_rdata = 64'h1234;
      settle();
      vec_cnt++; if (i_data_ok !== 1'b1) begin err_cnt++; $display("FAIL ird_data_ok: got %0b want 1", i_data_ok); end
      vec_cnt++; if (i_data !== 64'h1234) begin err_cnt++; $display("FAIL ird_data: got %h want 1234", i_data); end
      vec_cnt++; if ({d_data_ok, d_data} !== 65'd0) begin err_cnt++; $display("FAIL ird_dbus_quiet: got %h want 0", {d_data_ok, d_data}); end
      // cycle 4
      step();
      clear_inputs();
      settle();
      vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL ird_idle_c4: got %0d want 0", dbg_state); end
      vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL ird_mvalid_c4: got %0b want 0", m_valid); end
      vec_cnt++; if (dbg_last_grant !== 1'b0) begin err_cnt++; $display("FAIL ird_last_grant: got %0b want 0", dbg_last_grant); end
   endtask

   task automatic test_dbus_write();
      d_valid = 1'b1; d_addr = 64'h8000_0010; d_size = MSIZE4; d_strobe = 8'h0F;
      d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
      settle();
      vec_cnt++; if ({d_addr_ok, i_addr_ok} !== 2'b10) begin err_cnt++; $display("FAIL dwr_addr_ok: got %b want 10", {d_addr_ok, i_addr_ok}); end
      step();
      // later changes on the dbus inputs must not reach the latched outputs
      d_wdata = 64'h0; d_strobe = 8'hFF; d_addr = 64'h0;
      settle();
      vec_cnt++; if ({m_valid, m_write, m_strobe} !== {1'b1, 1'b1, 8'h0F}) begin err_cnt++; $display("FAIL dwr_mctrl: got %b want 1_1_00001111", {m_valid, m_write, m_strobe}); end
      vec_cnt++; if (m_addr !== 64'h8000_0010) begin err_cnt++; $display("FAIL dwr_maddr: got %h want 80000010", m_addr); end
      vec_cnt++; if (m_size !== MSIZE4) begin err_cnt++; $display("FAIL dwr_msize: got %0d want 2", m_size); end
      vec_cnt++; if (dbg_state !== ST_BD) begin err_cnt++; $display("FAIL dwr_state: got %0d want 2", dbg_state); end
      step();
      m_ready = 1'b1; m_rdata = 64'h0;
      settle();
      vec_cnt++; if (m_wdata !== 64'hDEAD_BEEF_CAFE_F00D) begin err_cnt++; $display("FAIL dwr_wdata_held: got %h want deadbeefcafef00d", m_wdata); end
      vec_cnt++; if ({d_data_ok, i_data_ok} !== 2'b10) begin err_cnt++; $display("FAIL dwr_data_ok: got %b want 10", {d_data_ok, i_data_ok}); end
      step();
      clear_inputs();
      settle();
      vec_cnt++; if ({dbg_state, m_valid, dbg_last_grant} !== {ST_IDLE, 1'b0, 1'b1}) begin err_cnt++; $display("FAIL dwr_end: got %b want 00_0_1", {dbg_state, m_valid, dbg_last_grant}); end
   endtask

   task automatic test_idle_ready();
      m_ready = 1'b1; m_rdata = 64'hFFFF_0000_FFFF_0000;
      settle();
      vec_cnt++; if ({i_data_ok, d_data_ok} !== 2'b00) begin err_cnt++; $display("FAIL idle_rdy_ok: got %b want 00", {i_data_ok, d_data_ok}); end
      vec_cnt++; if ({i_data, d_data} !== 128'd0) begin err_cnt++; $display("FAIL idle_rdy_data: got %h want 0", {i_data, d_data}); end
      step();
      clear_inputs();
      settle();
      vec_cnt++; if ({dbg_state, m_valid} !== 3'b000) begin err_cnt++; $display("FAIL idle_rdy_state: got %b want 000", {dbg_state, m_valid}); end
   endtask

   task automatic test_drop_valid();
      d_valid = 1'b1; d_addr = 64'h100; d_strobe = 8'h00; d_size = 3'd3;
      settle();
      vec_cnt++; if (d_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL drop_addr_ok: got %0b want 1", d_addr_ok); end
      step();
      d_valid = 1'b0; i_valid = 1'b1; i_addr = 64'h200;
      settle();
      vec_cnt++; if (i_addr_ok !== 1'b0) begin err_cnt++; $display("FAIL drop_i_waits: got %0b want 0", i_addr_ok); end
      vec_cnt++; if ({m_write, m_size} !== {1'b0, 3'd3}) begin err_cnt++; $display("FAIL drop_read: got %b want 0_011", {m_write, m_size}); end
      step();
      m_ready = 1'b1; m_rdata = 64'h55AA;
      settle();
      vec_cnt++; if ({d_data_ok, d_data} !== {1'b1, 64'h55AA}) begin err_cnt++; $display("FAIL drop_d_data: got %h want 1_55aa", {d_data_ok, d_data}); end
      vec_cnt++; if ({i_data_ok, i_data} !== 65'd0) begin err_cnt++; $display("FAIL drop_i_quiet: got %h want 0", {i_data_ok, i_data}); end
      step();
      m_ready = 1'b0; m_rdata = '0;
      settle();
      vec_cnt++; if ({dbg_state, m_valid, i_addr_ok} !== {ST_IDLE, 1'b0, 1'b1}) begin err_cnt++; $display("FAIL drop_bubble: got %b want 00_0_1", {dbg_state, m_valid, i_addr_ok}); end
      step();
      m_ready = 1'b1; m_rdata = 64'h0BAD_F00D;
      settle();
      vec_cnt++; if ({dbg_state, m_addr} !== {ST_BI, 64'h200}) begin err_cnt++; $display("FAIL drop_i_grant: got %h want 1_200", {dbg_state, m_addr}); end
      vec_cnt++; if ({i_data_ok, i_data} !== {1'b1, 64'h0BAD_F00D}) begin err_cnt++; $display("FAIL drop_i_data: got %h want 1_0badf00d", {i_data_ok, i_data}); end
      step();
      clear_inputs();
   endtask

   task automatic test_timeout();
      i_valid = 1'b1; i_addr = 64'h300; m_rdata = 64'hBAD;
      settle();
      vec_cnt++; if (i_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL to_addr_ok: got %0b want 1", i_addr_ok); end
      for (int c = 1; c <= 7; c++) begin
         step(); settle();
         vec_cnt++; if ({m_valid, i_data_ok, timeout} !== 3'b100) begin err_cnt++; $display("FAIL to_wait_c%0d: got %b want 100", c, {m_valid, i_data_ok, timeout}); end
      end
      step(); settle();
      vec_cnt++; if ({i_data_ok, i_data} !== {1'b1, 64'h0}) begin err_cnt++; $display("FAIL to_abort_c8: got %h want 1_0", {i_data_ok, i_data}); end
      step();
      clear_inputs();
      settle();
      vec_cnt++; if ({timeout, m_valid, dbg_state} !== {1'b1, 1'b0, ST_IDLE}) begin err_cnt++; $display("FAIL to_after: got %b want 1_0_00", {timeout, m_valid, dbg_state}); end
      // next request served normally, flag stays set
      d_valid = 1'b1; d_addr = 64'h400;
      settle();
      vec_cnt++; if (d_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL to_next_addr_ok: got %0b want 1", d_addr_ok); end
      step();
      step();
      m_ready = 1'b1; m_rdata = 64'h77;
      settle();
      vec_cnt++; if ({d_data_ok, d_data, timeout} !== {1'b1, 64'h77, 1'b1}) begin err_cnt++; $display("FAIL to_next_data: got %h want 1_77_1", {d_data_ok, d_data, timeout}); end
      step();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      d_valid = 1'b1; d_addr = 64'h500; d_strobe = 8'h03; d_wdata = 64'hAB;
      settle();
      step();
      step();
      // second BUSY cycle
      reset_n = 1'b0;
      #1;
      vec_cnt++; if ({m_valid, m_write, m_addr, timeout} !== 67'd0) begin err_cnt++; $display("FAIL rmid_outputs: got %h want 0", {m_valid, m_write, m_addr, timeout}); end
      vec_cnt++; if ({dbg_state, d_addr_ok, d_data_ok} !== 4'd0) begin err_cnt++; $display("FAIL rmid_state: got %b want 0000", {dbg_state, d_addr_ok, d_data_ok}); end
      step();
      reset_n = 1'b1;
      settle();
      vec_cnt++; if (d_addr_ok !== 1'b1) begin err_cnt++; $display("FAIL rmid_regrant: got %0b want 1", d_addr_ok); end
      step();
      m_ready = 1'b1;
      settle();
      vec_cnt++; if ({m_valid, m_addr, d_data_ok} !== {1'b1, 64'h500, 1'b1}) begin err_cnt++; $display("FAIL rmid_complete: got %h want 1_500_1", {m_valid, m_addr, d_data_ok}); end
      step();
      clear_inputs();
   endtask

   task automatic test_back_to_back_tie();
      logic exp_d [4];
`ifdef MEM_ARB_RR_EN
      exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      do_reset();
      i_valid = 1'b1; i_addr = 64'hA000;
      d_valid = 1'b1; d_addr = 64'hD000;
      for (int k = 0; k < 4; k++) begin
         settle();
         vec_cnt++; if ({d_addr_ok, i_addr_ok} !== {exp_d[k], ~exp_d[k]}) begin err_cnt++; $display("FAIL tie_grant_%0d: got %b want %b", k, {d_addr_ok, i_addr_ok}, {exp_d[k], ~exp_d[k]}); end
         step(); settle();
         vec_cnt++; if (m_addr !== (exp_d[k] ? 64'hD000 : 64'hA000)) begin err_cnt++; $display("FAIL tie_addr_%0d: got %h want %h", k, m_addr, exp_d[k] ? 64'hD000 : 64'hA000); end
         step();
         m_ready = 1'b1;
         settle();
         vec_cnt++; if ({d_data_ok, i_data_ok} !== {exp_d[k], ~exp_d[k]}) begin err_cnt++; $display("FAIL tie_done_%0d: got %b want %b", k, {d_data_ok, i_data_ok}, {exp_d[k], ~exp_d[k]}); end
         step();
         m_ready = 1'b0;
      end
      clear_inputs();
      step();
   endtask

   initial begin
      clear_inputs();
      reset_n = 1'b0;
      test_reset();
      test_ibus_read();
      test_dbus_write();
      test_idle_ready();
      test_drop_valid();
      test_timeout();
      test_reset_mid();
      test_back_to_back_tie();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
